// File: rtl/test_port_pkg.sv
// Shared types, default symbols and byte-order helper for the test-port result writer.
package test_port_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BEGIN_WR,
    GAP,
    FETCH,
    WORD_WR,
    END_WR,
    DONE
  } state_e;

  localparam logic [29:0] DEF_TEST_PORT = 30'h10;
  localparam logic [31:0] DEF_BEGIN_SYM = 32'h0000_0168;
  localparam logic [31:0] DEF_END_SYM   = 32'hFFFF_FD5D;

  // Readable (big-endian) word to little-endian bus order.
  function automatic logic [31:0] byteswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/test_port_writer_if.sv
// Producer handshake plus memory-mapped write bus seen by the test-port writer.
interface test_port_writer_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        mem_stall;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;

  modport master (
    input  word_valid, word_data, mem_stall,
    output word_ready, addr, data, wen
  );

  modport slave (
    output word_valid, word_data, mem_stall,
    input  word_ready, addr, data, wen
  );
endinterface

// File: rtl/test_port_writer.sv
// Frames producer result words as begin/payload/end writes to the test port.
// Optional watchdog abort is enabled by defining TEST_PORT_WRITER_TIMEOUT_EN.
module test_port_writer
  import test_port_pkg::*;
#(
  parameter logic [29:0] TEST_PORT   = DEF_TEST_PORT,
  parameter logic [31:0] BEGIN_SYM   = DEF_BEGIN_SYM,
  parameter logic [31:0] END_SYM     = DEF_END_SYM,
  parameter int          PAYLOAD_NUM = 18
`ifdef TEST_PORT_WRITER_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYC = 1024
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  test_port_writer_if.master        bus,
  output logic                      busy,
  output logic                      done,
  output logic [7:0]                words_sent
`ifdef TEST_PORT_WRITER_TIMEOUT_EN
  ,
  output logic                      timeout
`endif
);

  localparam logic [7:0] PAYLOAD_LIMIT = 8'(PAYLOAD_NUM);

  state_e      state;
  state_e      next_state;
  logic [31:0] word_q;
  logic        capture;
  logic        word_done;
  logic        start_ok;

`ifdef TEST_PORT_WRITER_TIMEOUT_EN
  // Abort fires on the TIMEOUT_CYC-th consecutive cycle spent in a waiting state.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] wdog;
  logic        abort;

  assign abort = (state == FETCH || state == BEGIN_WR || state == WORD_WR) &&
                 (wdog == WDOG_LAST);
`endif

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    next_state = state;
    capture    = 1'b0;
    word_done  = 1'b0;
    start_ok   = start && (state == IDLE || state == DONE);

    case (state)
      IDLE:     if (start) next_state = BEGIN_WR;
      BEGIN_WR: if (!bus.mem_stall) next_state = GAP;
      GAP:      next_state = (words_sent < PAYLOAD_LIMIT) ? FETCH : END_WR;
      FETCH: begin
        if (bus.word_valid) begin
          capture    = 1'b1;
          next_state = WORD_WR;
        end
      end
      WORD_WR: begin
        if (!bus.mem_stall) begin
          word_done  = 1'b1;
          next_state = GAP;
        end
      end
      END_WR:   if (!bus.mem_stall) next_state = DONE;
      DONE:     if (start) next_state = BEGIN_WR;
      default:  next_state = IDLE;
    endcase

`ifdef TEST_PORT_WRITER_TIMEOUT_EN
    if (abort) begin
      next_state = END_WR;
      capture    = 1'b0;
      word_done  = 1'b0;
    end
`endif
  end

  // Outputs are registered from next_state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      word_q         <= '0;
      words_sent     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.word_ready <= 1'b0;
      bus.wen        <= 1'b0;
      bus.addr       <= '0;
      bus.data       <= '0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      state <= next_state;
      if (capture) word_q <= bus.word_data;

      if (start_ok)
        words_sent <= '0;
      else if (word_done && words_sent != PAYLOAD_LIMIT)
        words_sent <= words_sent + 8'd1;

      busy           <= !(next_state == IDLE || next_state == DONE);
      done           <= (next_state == DONE);
      bus.word_ready <= (next_state == FETCH);

      bus.wen  <= 1'b0;
      bus.addr <= '0;
      bus.data <= '0;
      case (next_state)
        BEGIN_WR: begin
          bus.wen  <= 1'b1;
          bus.addr <= TEST_PORT;
          bus.data <= byteswap32(BEGIN_SYM);
        end
        WORD_WR: begin
          bus.wen  <= 1'b1;
          bus.addr <= TEST_PORT;
          bus.data <= byteswap32(capture ? bus.word_data : word_q);
        end
        END_WR: begin
          bus.wen  <= 1'b1;
          bus.addr <= TEST_PORT;
          bus.data <= byteswap32(END_SYM);
        end
        default: ;
      endcase
    end
  end

`ifdef TEST_PORT_WRITER_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog    <= '0;
      timeout <= 1'b0;
    end else begin
      if (next_state != state)
        wdog <= '0;
      else if (wdog != 16'hFFFF)
        wdog <= wdog + 16'd1;

      if (start_ok)
        timeout <= 1'b0;
      else if (abort)
        timeout <= 1'b1;
    end
  end
`endif

endmodule
